// File: rtl/dc_motor_pkg.sv
// Shared types and H-bridge leg encoding for the DC drive motor controller.
package dc_motor_pkg;

    localparam int CNT_W_DEF = 8;

    typedef enum logic [2:0] {
        IDLE,
        RAMP,
        RUN,
        DECEL_REV,
        DEAD,
        BRAKE
    } dcm_state_t;

    localparam logic [1:0] MA_OFF = 2'b00;
    localparam logic [1:0] MA_FWD = 2'b01;
    localparam logic [1:0] MA_REV = 2'b10;

    // Only one leg is ever driven; the other stays low.
    function automatic logic [1:0] ma_drive(input logic dir, input logic pwm);
        if (!pwm) return MA_OFF;
        return dir ? MA_REV : MA_FWD;
    endfunction

endpackage

// File: rtl/dc_motor_ctrl_if.sv
// Speed/direction command channel: valid/ready, one transfer per clock when both high.
interface dc_motor_ctrl_if #(
    parameter int CNT_W = dc_motor_pkg::CNT_W_DEF
) ();
    logic             cmd_valid;
    logic             cmd_ready;
    logic [CNT_W-1:0] cmd_speed;
    logic             cmd_dir;

    modport master (output cmd_valid, cmd_speed, cmd_dir, input cmd_ready);
    modport slave  (input cmd_valid, cmd_speed, cmd_dir, output cmd_ready);
endinterface

// File: rtl/dc_motor_pwm.sv
// Free-running PWM counter with wrap strobe; MA registered one clock after cnt/duty compare.
// No backpressure: counts every clock; duty must only change on wrap to avoid runt pulses.
module dc_motor_pwm
    import dc_motor_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [CNT_W-1:0] duty_i,
    input  logic             dir_i,
    output logic             wrap_o,
    output logic [1:0]       ma_o
);
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       ma_q;

    assign wrap_o = (cnt_q == {CNT_W{1'b1}});
    assign ma_o   = ma_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
            ma_q  <= MA_OFF;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
            ma_q  <= ma_drive(dir_i, cnt_q < duty_i);
        end
    end

endmodule

// File: rtl/dc_motor_ctrl.sv
// DC motor sequencer: soft start/stop (DC_MOTOR_SOFTSTART_EN), reversal dead time, brake; MA 1 clk after duty.
// cmd_ready low in DECEL_REV/DEAD/BRAKE and whenever brake is high; brake beats a same-cycle command.
module dc_motor_ctrl
    import dc_motor_pkg::*;
#(
    parameter int CNT_W    = CNT_W_DEF,
    parameter int DEAD_CYC = 64,
    parameter int RAMP_PER = 1
) (
    input  logic             clock,
    input  logic             reset,
    dc_motor_ctrl_if.slave   cmd,
    input  logic             brake,
    output logic [1:0]       MA,
    output logic             busy,
    output logic [CNT_W-1:0] duty
);
    // One timer serves both the dead interval and the ramp-period divider; they never overlap.
    localparam int TMR_MAX = (DEAD_CYC > RAMP_PER) ? DEAD_CYC : RAMP_PER;
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
    localparam logic [TMR_W-1:0] DEAD_LOAD = TMR_W'(DEAD_CYC - 1);

    dcm_state_t       state_q, state_d;
    logic [CNT_W-1:0] duty_q, duty_d;
    logic [CNT_W-1:0] tgt_speed_q, tgt_speed_d;
    logic             tgt_dir_q, tgt_dir_d;
    logic             cur_dir_q, cur_dir_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;

    logic             wrap;
    logic             cmd_rdy;
    logic             accept;
    logic             ramp_tick;
    logic [CNT_W-1:0] ramp_duty;
    logic [CNT_W-1:0] decel_duty;

    assign cmd_rdy = !brake && (state_q == IDLE || state_q == RAMP || state_q == RUN);
    assign accept  = cmd.cmd_valid && cmd_rdy;
    assign cmd.cmd_ready = cmd_rdy;

`ifdef DC_MOTOR_SOFTSTART_EN
    localparam logic [TMR_W-1:0] RAMP_LAST = TMR_W'(RAMP_PER - 1);
    assign ramp_tick  = wrap && (tmr_q == RAMP_LAST);
    assign ramp_duty  = (duty_q < tgt_speed_q) ? duty_q + CNT_W'(1) :
                        (duty_q > tgt_speed_q) ? duty_q - CNT_W'(1) : duty_q;
    assign decel_duty = (duty_q != '0) ? duty_q - CNT_W'(1) : '0;
`else
    assign ramp_tick  = wrap;
    assign ramp_duty  = tgt_speed_q;
    assign decel_duty = '0;
`endif

    always_comb begin
        state_d     = state_q;
        duty_d      = duty_q;
        tgt_speed_d = tgt_speed_q;
        tgt_dir_d   = tgt_dir_q;
        cur_dir_d   = cur_dir_q;
        tmr_d       = tmr_q;

        if (brake) begin
            state_d     = BRAKE;
            duty_d      = '0;
            tgt_speed_d = '0;
            tgt_dir_d   = cur_dir_q;
        end else if (accept) begin
            tgt_speed_d = cmd.cmd_speed;
            tgt_dir_d   = cmd.cmd_dir;
            if (cmd.cmd_dir != cur_dir_q) begin
                if (duty_q != '0)
                    state_d = DECEL_REV;
                else if (cmd.cmd_speed != '0 || state_q != IDLE)
                    state_d = DEAD;
            end else if (cmd.cmd_speed != duty_q) begin
                state_d = RAMP;
            end
        end else begin
            unique case (state_q)
                RAMP: begin
                    if (ramp_tick) begin
                        duty_d = ramp_duty;
                        if (ramp_duty == tgt_speed_q)
                            state_d = (tgt_speed_q == '0) ? IDLE : RUN;
                    end
                end
                DECEL_REV: begin
                    if (ramp_tick) begin
                        duty_d = decel_duty;
                        if (decel_duty == '0)
                            state_d = DEAD;
                    end
                end
                DEAD: begin
                    if (tmr_q == '0) begin
                        cur_dir_d = tgt_dir_q;
                        state_d   = (tgt_speed_q == '0) ? IDLE : RAMP;
                    end
                end
                BRAKE:   state_d = DEAD;
                default: ;
            endcase
        end

        if (state_d != state_q)
            tmr_d = (state_d == DEAD) ? DEAD_LOAD : '0;
        else if (state_q == DEAD) begin
            if (tmr_q != '0)
                tmr_d = tmr_q - 1'b1;
        end else if ((state_q == RAMP || state_q == DECEL_REV) && wrap)
            tmr_d = ramp_tick ? '0 : tmr_q + 1'b1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            duty_q      <= '0;
            tgt_speed_q <= '0;
            tgt_dir_q   <= 1'b0;
            cur_dir_q   <= 1'b0;
            tmr_q       <= '0;
        end else begin
            state_q     <= state_d;
            duty_q      <= duty_d;
            tgt_speed_q <= tgt_speed_d;
            tgt_dir_q   <= tgt_dir_d;
            cur_dir_q   <= cur_dir_d;
            tmr_q       <= tmr_d;
        end
    end

    dc_motor_pwm #(.CNT_W(CNT_W)) u_pwm (
        .clock  (clock),
        .reset  (reset),
        .duty_i (duty_q),
        .dir_i  (cur_dir_q),
        .wrap_o (wrap),
        .ma_o   (MA)
    );

    assign busy = (state_q != IDLE);
    assign duty = duty_q;

endmodule
